// File: rtl/riscv_base_trace_ctrl_pkg.sv
// Shared definitions for the trace capture controller.
//   - trc_state_e  : controller FSM encoding (IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3)
//   - TRC_DROP_W   : width of the saturating drop counter
//   - TRC_REC_W    : width of one buffered record {pc, opcode}
//   - trc_sat_inc  : saturating increment used by the 16-bit counters
package riscv_base_trace_ctrl_pkg;

    typedef enum logic [1:0] {
        TRC_IDLE    = 2'd0,
        TRC_ARMED   = 2'd1,
        TRC_CAPTURE = 2'd2,
        TRC_STOPPED = 2'd3
    } trc_state_e;

    localparam int unsigned TRC_DROP_W = 16;
    localparam int unsigned TRC_REC_W  = 64;

    function automatic logic [TRC_DROP_W-1:0] trc_sat_inc(input logic [TRC_DROP_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/riscv_base_trace_fifo.sv
// First-word-fall-through record FIFO used by riscv_base_trace_ctrl.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   push_i/data_i : write request and record; ignored while full
//   pop_i         : read request; ignored while empty
//   data_o        : head record, or the last popped record while empty
//   full_o/empty_o/level_o : status from the registered occupancy
module riscv_base_trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_last;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_level == LVL_FULL);
    assign empty_o = (r_level == '0);
    assign level_o = r_level;

    // A push is refused when full even if a pop frees a slot this cycle.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // When empty the output keeps showing the record that was last popped.
    assign data_o = empty_o ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/riscv_base_trace_ctrl.sv
// Trace capture controller between the retire stage and the trace decoder.
// Arms on arm_i, starts capturing when a retired PC matches trig_pc_i, buffers
// {pc, opcode} records in a FWFT FIFO and drains them one per valid/ready
// handshake. Stops on stop_i or after STOP_COUNT pushed records (0 = no limit).
// Ports:
//   clk_i, rst_i                      : clock, asynchronous active-high reset
//   retire_valid_i/pc_i/opcode_i      : retired instruction record
//   arm_i, stop_i, trig_pc_i          : control pulses and start-trigger PC
//   filt_base_i, filt_limit_i         : PC window [base, limit) (RISCV_TRACE_FILTER_EN only)
//   trace_valid_o/pc_o/opcode_o       : record presented to the decoder
//   trace_ready_i                     : decoder accepts the presented record
//   state_o, level_o, drop_cnt_o      : FSM state, FIFO occupancy, saturating drop count
// Build option: define RISCV_TRACE_FILTER_EN to add the PC window filter.
module riscv_base_trace_ctrl
    import riscv_base_trace_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STOP_COUNT = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    retire_valid_i,
    input  logic [31:0]             retire_pc_i,
    input  logic [31:0]             retire_opcode_i,
    input  logic                    arm_i,
    input  logic                    stop_i,
    input  logic [31:0]             trig_pc_i,
`ifdef RISCV_TRACE_FILTER_EN
    input  logic [31:0]             filt_base_i,
    input  logic [31:0]             filt_limit_i,
`endif
    output logic                    trace_valid_o,
    output logic [31:0]             trace_pc_o,
    output logic [31:0]             trace_opcode_o,
    input  logic                    trace_ready_i,
    output logic [1:0]              state_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic [15:0]             drop_cnt_o
);
    localparam logic [TRC_DROP_W-1:0] STOP_LIM = TRC_DROP_W'(STOP_COUNT);

    trc_state_e              r_state;
    trc_state_e              w_state_next;
    logic [TRC_DROP_W-1:0]   r_drop_cnt;
    logic [TRC_DROP_W-1:0]   r_cap_cnt;
    logic                    w_trig;
    logic                    w_in_range;
    logic                    w_limit_hit;
    logic                    w_push_req;
    logic                    w_clear;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic [TRC_REC_W-1:0]    w_fifo_dout;

    // Trigger detection is never filtered; only record eligibility is.
    assign w_trig = retire_valid_i && (retire_pc_i == trig_pc_i);

`ifdef RISCV_TRACE_FILTER_EN
    assign w_in_range = (retire_pc_i >= filt_base_i) && (retire_pc_i < filt_limit_i);
`else
    assign w_in_range = 1'b1;
`endif

    // The limit is seen on the registered count, so the stop lands one edge
    // after the final record; no further push is allowed in that cycle.
    assign w_limit_hit = (STOP_LIM != '0) && (r_cap_cnt >= STOP_LIM);

    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            TRC_IDLE: begin
                if (arm_i) w_state_next = TRC_ARMED;
            end
            TRC_ARMED: begin
                if (stop_i) begin
                    w_state_next = TRC_STOPPED;
                end else if (w_trig) begin
                    w_state_next = TRC_CAPTURE;
                    w_push_req   = w_in_range;
                end
            end
            TRC_CAPTURE: begin
                if (stop_i || w_limit_hit) begin
                    w_state_next = TRC_STOPPED;
                end else begin
                    w_push_req = retire_valid_i && w_in_range;
                end
            end
            TRC_STOPPED: begin
                if (arm_i) begin
                    w_state_next = TRC_ARMED;
                    w_clear      = 1'b1;
                end
            end
            default: w_state_next = TRC_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= TRC_IDLE;
            r_drop_cnt <= '0;
            r_cap_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clear) begin
                r_drop_cnt <= '0;
                r_cap_cnt  <= '0;
            end else if (w_push_req) begin
                if (w_full) r_drop_cnt <= trc_sat_inc(r_drop_cnt);
                else        r_cap_cnt  <= trc_sat_inc(r_cap_cnt);
            end
        end
    end

    assign w_pop = !w_empty && trace_ready_i;

    riscv_base_trace_fifo #(
        .WIDTH (TRC_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push_req),
        .data_i  ({retire_pc_i, retire_opcode_i}),
        .pop_i   (w_pop),
        .data_o  (w_fifo_dout),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    assign trace_valid_o  = !w_empty;
    assign trace_pc_o     = w_fifo_dout[63:32];
    assign trace_opcode_o = w_fifo_dout[31:0];
    assign state_o        = r_state;
    assign drop_cnt_o     = r_drop_cnt;

endmodule

// File: tb/tb_riscv_base_trace_ctrl.sv
module tb_riscv_base_trace_ctrl;
    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        rv;
    logic [31:0] pc_in;
    logic [31:0] op_in;
    logic        arm;
    logic        stop;
    logic [31:0] trig;
    logic        ready;
`ifdef RISCV_TRACE_FILTER_EN
    logic [31:0] fbase;
    logic [31:0] flimit;
`endif

    logic        dut_valid, lim_valid;
    logic [31:0] dut_pc, dut_op, lim_pc, lim_op;
    logic [1:0]  dut_state, lim_state;
    logic [2:0]  dut_level, lim_level;
    logic [15:0] dut_drop, lim_drop;

    riscv_base_trace_ctrl #(.DEPTH(DEPTH), .STOP_COUNT(0)) dut (
        .clk_i(clk), .rst_i(rst), .retire_valid_i(rv), .retire_pc_i(pc_in),
        .retire_opcode_i(op_in), .arm_i(arm), .stop_i(stop), .trig_pc_i(trig),
`ifdef RISCV_TRACE_FILTER_EN
        .filt_base_i(fbase), .filt_limit_i(flimit),
`endif
        .trace_valid_o(dut_valid), .trace_pc_o(dut_pc), .trace_opcode_o(dut_op),
        .trace_ready_i(ready), .state_o(dut_state), .level_o(dut_level),
        .drop_cnt_o(dut_drop)
    );

    riscv_base_trace_ctrl #(.DEPTH(DEPTH), .STOP_COUNT(3)) dut_lim (
        .clk_i(clk), .rst_i(rst), .retire_valid_i(rv), .retire_pc_i(pc_in),
        .retire_opcode_i(op_in), .arm_i(arm), .stop_i(stop), .trig_pc_i(trig),
`ifdef RISCV_TRACE_FILTER_EN
        .filt_base_i(fbase), .filt_limit_i(flimit),
`endif
        .trace_valid_o(lim_valid), .trace_pc_o(lim_pc), .trace_opcode_o(lim_op),
        .trace_ready_i(ready), .state_o(lim_state), .level_o(lim_level),
        .drop_cnt_o(lim_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model of the unlimited instance: queue of buffered records.
    int          m_state;
    logic [63:0] mq[$];
    logic [63:0] m_acc[$];
    logic [63:0] popped[$];
    logic [63:0] m_last;
    int          m_drop;

    task automatic model_reset();
        m_state = 0;
        mq.delete();
        m_acc.delete();
        popped.delete();
        m_last = '0;
        m_drop = 0;
    endtask

    task automatic model_step();
        logic [63:0] rec;
        bit pop, full, push, eligible, clr;
        int ns;
        rec      = {pc_in, op_in};
        eligible = 1'b1;
`ifdef RISCV_TRACE_FILTER_EN
        eligible = (pc_in >= fbase) && (pc_in < flimit);
`endif
        pop  = (mq.size() != 0) && ready;
        full = (mq.size() == DEPTH);
        push = 1'b0;
        clr  = 1'b0;
        ns   = m_state;
        if (m_state == 0) begin
            if (arm) ns = 1;
        end else if (m_state == 1) begin
            if (stop) ns = 3;
            else if (rv && pc_in == trig) begin ns = 2; push = eligible; end
        end else if (m_state == 2) begin
            if (stop) ns = 3;
            else push = rv && eligible;
        end else begin
            if (arm) begin ns = 1; clr = 1'b1; end
        end
        if (pop) m_last = mq.pop_front();
        if (push) begin
            if (full) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                mq.push_back(rec);
                m_acc.push_back(rec);
            end
        end
        if (clr) m_drop = 0;
        m_state = ns;
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic cycle();
        if (dut_valid && ready) popped.push_back({dut_pc, dut_op});
        model_step();
        @(posedge clk);
        #1;
        chk("state", 64'(dut_state), 64'(m_state));
        chk("valid", 64'(dut_valid), 64'(mq.size() != 0));
        chk("level", 64'(dut_level), 64'(mq.size()));
        chk("drop", 64'(dut_drop), 64'(m_drop));
        chk("record", {dut_pc, dut_op}, (mq.size() != 0) ? mq[0] : m_last);
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = 1'b0; pc_in = '0; op_in = '0;
        arm = 1'b0; stop = 1'b0; trig = '0; ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic retire(input logic [31:0] p, input logic [31:0] o);
        rv = 1'b1; pc_in = p; op_in = o;
        cycle();
        rv = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cycle(); arm = 1'b0;
    endtask

    typedef struct {
        logic        arm, stop, rv;
        logic [31:0] pc, op;
        logic        ready;
        logic [1:0]  e_state;
        logic        e_valid;
        logic [31:0] e_pc, e_op;
        logic [2:0]  e_level;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lexp_pc[4];
        logic [31:0] lexp_op[4];
        int sent;

        tbl[0] = '{1, 0, 0, 32'h00, 32'h0,        1, 2'd1, 0, 32'h00, 32'h0,        3'd0};
        tbl[1] = '{0, 0, 1, 32'h00, 32'h13,       1, 2'd1, 0, 32'h00, 32'h0,        3'd0};
        tbl[2] = '{0, 0, 1, 32'h04, 32'h13,       1, 2'd1, 0, 32'h00, 32'h0,        3'd0};
        tbl[3] = '{0, 0, 1, 32'h10, 32'h010000ef, 1, 2'd2, 1, 32'h10, 32'h010000ef, 3'd1};
        tbl[4] = '{0, 0, 1, 32'h14, 32'h00008067, 1, 2'd2, 1, 32'h14, 32'h00008067, 3'd1};
        tbl[5] = '{0, 0, 0, 32'h00, 32'h0,        1, 2'd2, 0, 32'h14, 32'h00008067, 3'd0};
        tbl[6] = '{0, 1, 0, 32'h00, 32'h0,        1, 2'd3, 0, 32'h14, 32'h00008067, 3'd0};
`ifdef RISCV_TRACE_FILTER_EN
        fbase = '0; flimit = '1;
`endif

        // Reset state
        do_reset();
        chk("rst_state", 64'(dut_state), 64'd0);
        chk("rst_valid", 64'(dut_valid), 64'd0);
        chk("rst_pc", 64'(dut_pc), 64'd0);
        chk("rst_level", 64'(dut_level), 64'd0);
        chk("rst_drop", 64'(dut_drop), 64'd0);

        // Trigger sequence from the table
        trig = 32'h10;
        for (int i = 0; i < 7; i++) begin
            arm = tbl[i].arm; stop = tbl[i].stop; rv = tbl[i].rv;
            pc_in = tbl[i].pc; op_in = tbl[i].op; ready = tbl[i].ready;
            cycle();
            chk($sformatf("tbl%0d_state", i), 64'(dut_state), 64'(tbl[i].e_state));
            chk($sformatf("tbl%0d_valid", i), 64'(dut_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_rec", i), {dut_pc, dut_op}, {tbl[i].e_pc, tbl[i].e_op});
            chk($sformatf("tbl%0d_level", i), 64'(dut_level), 64'(tbl[i].e_level));
        end
        arm = 0; stop = 0; rv = 0;

        // Overflow: six records into a four-deep FIFO with no consumer
        do_reset();
        trig = 32'h100;
        pulse_arm();
        for (int k = 0; k < 6; k++) retire(32'h100 + 32'(4 * k), 32'hA00 + 32'(k));
        chk("ovf_level", 64'(dut_level), 64'd4);
        chk("ovf_drop", 64'(dut_drop), 64'd2);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("ovf_valid", 64'(dut_valid), 64'd1);
            chk("ovf_pc", 64'(dut_pc), 64'(32'h100 + 32'(4 * k)));
            cycle();
        end
        chk("ovf_empty", 64'(dut_valid), 64'd0);
        ready = 1'b0;

        // Limit (STOP_COUNT=3 instance), re-arm keeps FIFO, clears drops
        do_reset();
        trig = 32'h200;
        pulse_arm();
        for (int k = 0; k < 5; k++) retire(32'h200 + 32'(4 * k), 32'hB00 + 32'(k));
        chk("lim_state", 64'(lim_state), 64'd3);
        chk("lim_level", 64'(lim_level), 64'd3);
        pulse_arm();
        chk("lim_rearm_state", 64'(lim_state), 64'd1);
        chk("lim_rearm_level", 64'(lim_level), 64'd3);
        retire(32'h200, 32'hC00);
        retire(32'h204, 32'hC01);
        retire(32'h208, 32'hC02);
        chk("lim_drop", 64'(lim_drop), 64'd2);
        chk("lim_cap_state", 64'(lim_state), 64'd2);
        chk("lim_full", 64'(lim_level), 64'd4);
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("lim_stop_state", 64'(lim_state), 64'd3);
        pulse_arm();
        chk("lim_arm_state", 64'(lim_state), 64'd1);
        chk("lim_arm_drop", 64'(lim_drop), 64'd0);
        lexp_pc = '{32'h200, 32'h204, 32'h208, 32'h200};
        lexp_op = '{32'hB00, 32'hB01, 32'hB02, 32'hC00};
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("lim_out_valid", 64'(lim_valid), 64'd1);
            chk("lim_out_rec", {lim_pc, lim_op}, {lexp_pc[k], lexp_op[k]});
            cycle();
        end
        chk("lim_out_empty", 64'(lim_valid), 64'd0);
        ready = 1'b0;

        // Backpressure: 20 records, random gaps and random ready
        do_reset();
        trig = 32'h400;
        pulse_arm();
        ready = 1'($urandom_range(0, 1));
        retire(32'h400, 32'hD00);
        sent = 1;
        for (int c = 0; c < 400 && sent < 20; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                retire(32'h400 + 32'(4 * sent), 32'hD00 + 32'(sent));
                sent++;
            end else begin
                cycle();
            end
        end
        chk("bp_sent", 64'(sent), 64'd20);
        ready = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) cycle();
        chk("bp_count", 64'(popped.size()), 64'(20 - m_drop));
        chk("bp_acc_count", 64'(popped.size()), 64'(m_acc.size()));
        for (int i = 0; i < popped.size() && i < m_acc.size(); i++)
            chk("bp_order", popped[i], m_acc[i]);
        ready = 1'b0;

        // Stop with coincident record, then asynchronous reset mid-capture
        do_reset();
        trig = 32'h300;
        pulse_arm();
        retire(32'h300, 32'hE00);
        stop = 1'b1;
        retire(32'h304, 32'hE01);
        stop = 1'b0;
        chk("stop_state", 64'(dut_state), 64'd3);
        chk("stop_level", 64'(dut_level), 64'd1);
        pulse_arm();
        retire(32'h300, 32'hE02);
        retire(32'h304, 32'hE03);
        chk("pre_rst_level", 64'(dut_level), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(dut_valid), 64'd0);
        chk("async_rst_state", 64'(dut_state), 64'd0);
        chk("async_rst_level", 64'(dut_level), 64'd0);
        do_reset();

`ifdef RISCV_TRACE_FILTER_EN
        // PC window filter
        fbase = 32'h40; flimit = 32'h60;
        trig = 32'h3c;
        pulse_arm();
        retire(32'h3c, 32'hF00);
        retire(32'h40, 32'hF01);
        retire(32'h5c, 32'hF02);
        retire(32'h60, 32'hF03);
        chk("filt_level", 64'(dut_level), 64'd2);
        ready = 1'b1;
        chk("filt_pc0", 64'(dut_pc), 64'h40);
        cycle();
        chk("filt_pc1", 64'(dut_pc), 64'h5c);
        cycle();
        chk("filt_empty", 64'(dut_valid), 64'd0);
        ready = 1'b0;
        fbase = '0; flimit = '1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
